// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, default widths and requester port identifiers.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input winner select: fixed CPU priority or round-robin on the
// previous winner. Purely combinational.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int CPU_PRIO = 1
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_last,
  output logic o_any,
  output logic o_winner
);

  always_comb begin
    o_any    = i_req0 | i_req1;
    o_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      // On a tie round-robin hands the grant to whoever did not win last
      o_winner = (CPU_PRIO != 0) ? PORT_CPU : ~i_rr_last;
    end else if (i_req1) begin
      o_winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the CPU MEM stage (port 0)
// and the debug/loader DMA (port 1), one access every three cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int CPU_PRIO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              cpu_stall,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmem_state_e       r_state;
  dmem_state_e       w_state_next;
  logic              r_grant;
  logic              r_rr_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              w_any;
  logic              w_win;
  logic              w_latch;

  dmem_rr_pick #(
    .CPU_PRIO (CPU_PRIO)
  ) u_pick (
    .i_req0    (p0_req),
    .i_req1    (p1_req),
    .i_rr_last (r_rr_last),
    .o_any     (w_any),
    .o_winner  (w_win)
  );

  assign w_latch = (r_state == IDLE) && w_any;

  always_comb begin
    w_state_next = r_state;
    mem_memwrite = 1'b0;
    mem_memread  = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    p0_ack       = 1'b0;
    p1_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_next = ISSUE;
      end
      ISSUE: begin
        mem_memwrite = r_we;
        mem_memread  = ~r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        w_state_next = RESP;
      end
      RESP: begin
        p0_ack       = (r_grant == PORT_CPU);
        p1_ack       = (r_grant == PORT_DMA);
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read data is forwarded straight from the memory during the ack cycle and
  // held in the port register from then on.
  assign p0_rdata  = (p0_ack && !r_we) ? mem_rdata : r_p0_rdata;
  assign p1_rdata  = (p1_ack && !r_we) ? mem_rdata : r_p1_rdata;
  assign cpu_stall = p0_req & ~p0_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= PORT_CPU;
      r_rr_last  <= PORT_DMA;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_grant   <= w_win;
        r_rr_last <= w_win;
        r_we      <= (w_win == PORT_DMA) ? p1_we    : p0_we;
        r_addr    <= (w_win == PORT_DMA) ? p1_addr  : p0_addr;
        r_wdata   <= (w_win == PORT_DMA) ? p1_wdata : p0_wdata;
      end
      if ((r_state == RESP) && !r_we) begin
        if (r_grant == PORT_DMA) r_p1_rdata <= mem_rdata;
        else                     r_p0_rdata <= mem_rdata;
      end
    end
  end

endmodule
